// File: rtl/bot_if_pkg.sv
// bot_if_pkg
// Shared constants for the multi-bot PicoBlaze I/O interface.
//   - kcpsm6 port addresses for the global registers, bot windows and display
//   - register offsets inside each 8-byte bot window
//   - MAX_BOTS and the interrupt source register layout plus its encoder
package bot_if_pkg;

    localparam int MAX_BOTS = 4;

    // Switch reads and LED writes share addresses 0x01/0x02.
    localparam logic [7:0] P_BTNS       = 8'h00;
    localparam logic [7:0] P_SWLO       = 8'h01;
    localparam logic [7:0] P_SWHI       = 8'h02;
    localparam logic [7:0] P_PEND       = 8'h03;
    localparam logic [7:0] P_MASK       = 8'h04;
    localparam logic [7:0] P_SRC        = 8'h05;
    localparam logic [7:0] P_BOT_BASE   = 8'h10;
    localparam logic [7:0] P_BOT_STRIDE = 8'h08;
    localparam logic [7:0] P_DIG_BASE   = 8'h20;
    localparam logic [7:0] P_DP         = 8'h28;

    localparam logic [2:0] OFF_LOCX    = 3'd0;
    localparam logic [2:0] OFF_LOCY    = 3'd1;
    localparam logic [2:0] OFF_BOTINFO = 3'd2;
    localparam logic [2:0] OFF_SENSORS = 3'd3;
    localparam logic [2:0] OFF_LMDIST  = 3'd4;
    localparam logic [2:0] OFF_RMDIST  = 3'd5;
    localparam logic [2:0] OFF_OVRCNT  = 3'd6;

    typedef struct packed {
        logic       valid;
        logic [4:0] zero;
        logic [1:0] id;
    } src_reg_t;

    // Lowest-index requesting bot wins.
    function automatic src_reg_t lowest_pending(input logic [MAX_BOTS-1:0] req);
        src_reg_t r;
        r = '0;
        for (int i = MAX_BOTS - 1; i >= 0; i--) begin
            if (req[i]) begin
                r.valid = 1'b1;
                r.id    = 2'(i);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/bot_irq_ctrl.sv
// bot_irq_ctrl
// Per-bot maskable interrupt controller for pico_bot_if_n.
// Optional feature macro: BOT_IF_OVERRUN_CNT_EN (per-bot saturating overrun counters).
// Ports:
//   clk, reset        clock, async active-high reset
//   upd               per-bot update pulses (set pending)
//   mask_we/wdata     irq mask write
//   clr_we/wdata      write-1-to-clear of pending bits
//   ack               interrupt acknowledge, clears the bit named by the source register
//   cnt_clr           per-bot overrun counter clear
//   pending, mask     current register values
//   irq               registered interrupt request
//   src               registered source register {valid,5'b0,id}
//   ovr_cnt           packed overrun counters, bot b at [8b+7:8b] (zero when disabled)
module bot_irq_ctrl
    import bot_if_pkg::*;
#(
    parameter int NUM_BOTS = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_BOTS-1:0]   upd,
    input  logic                  mask_we,
    input  logic [NUM_BOTS-1:0]   mask_wdata,
    input  logic                  clr_we,
    input  logic [NUM_BOTS-1:0]   clr_wdata,
    input  logic                  ack,
    input  logic [NUM_BOTS-1:0]   cnt_clr,
    output logic [NUM_BOTS-1:0]   pending,
    output logic [NUM_BOTS-1:0]   mask,
    output logic                  irq,
    output logic [7:0]            src,
    output logic [8*NUM_BOTS-1:0] ovr_cnt
);

    logic [NUM_BOTS-1:0] pending_q, pending_d;
    logic [NUM_BOTS-1:0] mask_q, mask_d;
    logic                irq_q, irq_d;
    src_reg_t            src_q, src_d;
    logic [MAX_BOTS-1:0] req;
    logic [NUM_BOTS-1:0] ack_clr;

    // Clears are applied before the update pulses so that a simultaneous
    // set always survives.
    always_comb begin
        req     = '0;
        ack_clr = '0;
        for (int b = 0; b < NUM_BOTS; b++) begin
            req[b] = pending_q[b] & mask_q[b];
            if (src_q.valid && (src_q.id == 2'(b))) begin
                ack_clr[b] = ack;
            end
        end
        irq_d     = |req;
        src_d     = lowest_pending(req);
        pending_d = pending_q & ~ack_clr;
        if (clr_we) begin
            pending_d = pending_d & ~clr_wdata;
        end
        pending_d = pending_d | upd;
        mask_d    = mask_we ? mask_wdata : mask_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending_q <= '0;
            mask_q    <= '0;
            irq_q     <= 1'b0;
            src_q     <= '0;
        end else begin
            pending_q <= pending_d;
            mask_q    <= mask_d;
            irq_q     <= irq_d;
            src_q     <= src_d;
        end
    end

    assign pending = pending_q;
    assign mask    = mask_q;
    assign irq     = irq_q;
    assign src     = src_q;

`ifdef BOT_IF_OVERRUN_CNT_EN
    logic [NUM_BOTS-1:0][7:0] cnt_q, cnt_d;
    logic [NUM_BOTS-1:0]      ovr_inc;

    // An overrun is an update arriving while the previous one is still pending.
    assign ovr_inc = upd & pending_q;

    // A clear concurrent with an overrun restarts the count at one.
    always_comb begin
        cnt_d = cnt_q;
        for (int b = 0; b < NUM_BOTS; b++) begin
            if (cnt_clr[b]) begin
                cnt_d[b] = ovr_inc[b] ? 8'd1 : 8'd0;
            end else if (ovr_inc[b] && (cnt_q[b] != 8'hFF)) begin
                cnt_d[b] = cnt_q[b] + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign ovr_cnt = cnt_q;
`else
    logic unused_cnt_clr;

    assign unused_cnt_clr = |cnt_clr;
    assign ovr_cnt        = '0;
`endif

endmodule

// File: rtl/pico_bot_if_n.sv
// pico_bot_if_n
// kcpsm6 I/O interface serving NUM_BOTS RojoBot channels from one PicoBlaze.
// Optional feature macro: BOT_IF_OVERRUN_CNT_EN (overrun counters at 0x10+8b+6).
// Ports:
//   clk, reset                     clock, async active-high reset
//   pb_port_id/out_port            kcpsm6 address and write data
//   pb_write_strobe/k_write_strobe normal and constant-optimised output strobes
//   pb_read_strobe                 input strobe (only clears overrun counters)
//   pb_interrupt_ack/pb_interrupt  interrupt handshake
//   pb_in_port                     registered read data
//   bot_*                          packed per-bot registers, bot b at [8b+7:8b]
//   bot_upd_sysreg                 per-bot update pulses
//   bot_motctl                     packed per-bot motor control
//   db_btns, db_sw                 debounced buttons and switches
//   led, dig0..dig7, dp            LEDs and seven-segment digit codes / decimal points
module pico_bot_if_n
    import bot_if_pkg::*;
#(
    parameter int NUM_BOTS = 2,
    parameter int DIG_W    = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [7:0]            pb_port_id,
    input  logic [7:0]            pb_out_port,
    input  logic                  pb_write_strobe,
    input  logic                  pb_k_write_strobe,
    input  logic                  pb_read_strobe,
    input  logic                  pb_interrupt_ack,
    output logic [7:0]            pb_in_port,
    output logic                  pb_interrupt,
    input  logic [8*NUM_BOTS-1:0] bot_locX,
    input  logic [8*NUM_BOTS-1:0] bot_locY,
    input  logic [8*NUM_BOTS-1:0] bot_botinfo,
    input  logic [8*NUM_BOTS-1:0] bot_sensors,
    input  logic [8*NUM_BOTS-1:0] bot_lmdist,
    input  logic [8*NUM_BOTS-1:0] bot_rmdist,
    input  logic [NUM_BOTS-1:0]   bot_upd_sysreg,
    output logic [8*NUM_BOTS-1:0] bot_motctl,
    input  logic [4:0]            db_btns,
    input  logic [15:0]           db_sw,
    output logic [15:0]           led,
    output logic [DIG_W-1:0]      dig0,
    output logic [DIG_W-1:0]      dig1,
    output logic [DIG_W-1:0]      dig2,
    output logic [DIG_W-1:0]      dig3,
    output logic [DIG_W-1:0]      dig4,
    output logic [DIG_W-1:0]      dig5,
    output logic [DIG_W-1:0]      dig6,
    output logic [DIG_W-1:0]      dig7,
    output logic [7:0]            dp
);

    localparam logic [7:0] BOT_END = 8'(P_BOT_BASE + NUM_BOTS * P_BOT_STRIDE);

    logic [7:0]                 in_port_q, in_port_d;
    logic [15:0]                led_q, led_d;
    logic [8*NUM_BOTS-1:0]      motctl_q, motctl_d;
    logic [7:0][DIG_W-1:0]      dig_q, dig_d;
    logic [7:0]                 dp_q, dp_d;

    logic [4:0]                 bot_rel;
    logic                       mask_we, clr_we;
    logic [NUM_BOTS-1:0]        cnt_clr;
    logic [NUM_BOTS-1:0]        pending, mask;
    logic [7:0]                 src;
    logic [8*NUM_BOTS-1:0]      ovr_cnt;

    // Offset into the bot windows; wraps so 0x10..0x2F maps to 0..31.
    assign bot_rel = pb_port_id[4:0] - P_BOT_BASE[4:0];

    assign mask_we = pb_write_strobe && (pb_port_id == P_MASK);
    assign clr_we  = pb_write_strobe && (pb_port_id == P_SRC);

    always_comb begin
        cnt_clr = '0;
        for (int b = 0; b < NUM_BOTS; b++) begin
            cnt_clr[b] = pb_read_strobe &&
                (pb_port_id == 8'(P_BOT_BASE + b * P_BOT_STRIDE + OFF_OVRCNT));
        end
    end

    bot_irq_ctrl #(
        .NUM_BOTS(NUM_BOTS)
    ) u_irq (
        .clk       (clk),
        .reset     (reset),
        .upd       (bot_upd_sysreg),
        .mask_we   (mask_we),
        .mask_wdata(pb_out_port[NUM_BOTS-1:0]),
        .clr_we    (clr_we),
        .clr_wdata (pb_out_port[NUM_BOTS-1:0]),
        .ack       (pb_interrupt_ack),
        .cnt_clr   (cnt_clr),
        .pending   (pending),
        .mask      (mask),
        .irq       (pb_interrupt),
        .src       (src),
        .ovr_cnt   (ovr_cnt)
    );

    // Read data is captured every cycle regardless of pb_read_strobe.
    always_comb begin
        in_port_d = 8'h00;
        case (pb_port_id)
            P_BTNS: in_port_d = {3'b000, db_btns};
            P_SWLO: in_port_d = db_sw[7:0];
            P_SWHI: in_port_d = db_sw[15:8];
            P_PEND: for (int b = 0; b < NUM_BOTS; b++) in_port_d[b] = pending[b];
            P_MASK: for (int b = 0; b < NUM_BOTS; b++) in_port_d[b] = mask[b];
            P_SRC:  in_port_d = src;
            default: begin
                if ((pb_port_id >= P_BOT_BASE) && (pb_port_id < BOT_END)) begin
                    for (int b = 0; b < NUM_BOTS; b++) begin
                        if (bot_rel[4:3] == 2'(b)) begin
                            case (bot_rel[2:0])
                                OFF_LOCX:    in_port_d = bot_locX[8*b +: 8];
                                OFF_LOCY:    in_port_d = bot_locY[8*b +: 8];
                                OFF_BOTINFO: in_port_d = bot_botinfo[8*b +: 8];
                                OFF_SENSORS: in_port_d = bot_sensors[8*b +: 8];
                                OFF_LMDIST:  in_port_d = bot_lmdist[8*b +: 8];
                                OFF_RMDIST:  in_port_d = bot_rmdist[8*b +: 8];
                                OFF_OVRCNT:  in_port_d = ovr_cnt[8*b +: 8];
                                default:     in_port_d = 8'h00;
                            endcase
                        end
                    end
                end
            end
        endcase
    end

    // With NUM_BOTS > 2 the motctl addresses of bots 2/3 alias the digit/dp
    // addresses; both targets are then written.
    always_comb begin
        led_d    = led_q;
        motctl_d = motctl_q;
        dig_d    = dig_q;
        dp_d     = dp_q;
        if (pb_write_strobe) begin
            if (pb_port_id == P_SWLO) led_d[7:0]  = pb_out_port;
            if (pb_port_id == P_SWHI) led_d[15:8] = pb_out_port;
            for (int b = 0; b < NUM_BOTS; b++) begin
                if (pb_port_id == 8'(P_BOT_BASE + b * P_BOT_STRIDE)) begin
                    motctl_d[8*b +: 8] = pb_out_port;
                end
            end
            if (pb_port_id[7:3] == P_DIG_BASE[7:3]) begin
                dig_d[pb_port_id[2:0]] = pb_out_port[DIG_W-1:0];
            end
            if (pb_port_id == P_DP) dp_d = pb_out_port;
        end
        // OUTPUTK only carries a 4-bit port address.
        if (pb_k_write_strobe) begin
            if (!pb_port_id[3]) begin
                dig_d[pb_port_id[2:0]] = pb_out_port[DIG_W-1:0];
            end else if (pb_port_id[2:0] == 3'b000) begin
                dp_d = pb_out_port;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            in_port_q <= '0;
            led_q     <= '0;
            motctl_q  <= '0;
            dig_q     <= '0;
            dp_q      <= '0;
        end else begin
            in_port_q <= in_port_d;
            led_q     <= led_d;
            motctl_q  <= motctl_d;
            dig_q     <= dig_d;
            dp_q      <= dp_d;
        end
    end

    assign pb_in_port = in_port_q;
    assign bot_motctl = motctl_q;
    assign led        = led_q;
    assign dp         = dp_q;
    assign dig0       = dig_q[0];
    assign dig1       = dig_q[1];
    assign dig2       = dig_q[2];
    assign dig3       = dig_q[3];
    assign dig4       = dig_q[4];
    assign dig5       = dig_q[5];
    assign dig6       = dig_q[6];
    assign dig7       = dig_q[7];

endmodule
